// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dff_bank_arbiter
//  Description : Round-robin arbiter that loads one of NREQ requesters' data
//                into a shared WIDTH-bit register. It then locks the register
//                for HOLD cycles before the next arbitration.
//  Revision    : 1.0  initial release
// ============================================================================
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data,
    output logic [NREQ-1:0]           gnt,
    output logic [WIDTH-1:0]          Q,
    output logic [WIDTH-1:0]          Q_bar,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      valid,
    output logic                      busy
);

    localparam int PW = $clog2(NREQ);
    // One spare bit so that ptr + offset can be compared against NREQ before wrapping
    localparam int SW = PW + 1;
    // Lock counter needs to hold HOLD-1, but is never narrower than one bit
    localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [CW-1:0] C_CNT_LOAD = CW'((HOLD > 0) ? HOLD - 1 : 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] slice [NREQ];
    logic [PW-1:0]    winner;
    logic [SW-1:0]    scan_idx;
    logic             found;
    logic             do_grant;

    // Split the flat data bus into one slice per requester
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice[i] = data[i*WIDTH +: WIDTH];
    end

    // State register: every flop of the block, synchronous active-high reset
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
        end
    end

    // Round-robin scan: first requester at or after ptr, wrapping past NREQ-1
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = SW'(ptr_q) + SW'(k);
            if (scan_idx >= SW'(NREQ)) begin
                scan_idx = scan_idx - SW'(NREQ);
            end
            if (!found && req[scan_idx[PW-1:0]]) begin
                winner = scan_idx[PW-1:0];
                found  = 1'b1;
            end
        end
    end

    // Next-state logic: enter LOCK after a grant, leave once the count runs out
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (do_grant && (HOLD > 0)) begin
                    state_d = S_LOCK;
                    cnt_d   = C_CNT_LOAD;
                end
            end
            S_LOCK: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath logic: grant only in IDLE; everything else holds
    always_comb begin
        do_grant = (state_q == S_IDLE) && (|req);
        busy     = (state_q == S_LOCK);
        q_d      = q_q;
        owner_d  = owner_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        if (do_grant) begin
            q_d           = slice[winner];
            owner_d       = winner;
            valid_d       = 1'b1;
            gnt_d[winner] = 1'b1;
            ptr_d         = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
        end
    end

    assign gnt   = gnt_q;
    assign Q     = q_q;
    assign Q_bar = ~q_q;
    assign owner = owner_q;
    assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dff_bank_arbiter
//  Description : Self-checking bench for dff_bank_arbiter (HOLD=2 and HOLD=0
//                instances) against a lock-countdown reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ-1:0]       req0  = '0;
    logic [NREQ*WIDTH-1:0] data  = '0;
    logic [NREQ*WIDTH-1:0] data0 = '0;

    logic [NREQ-1:0]  gnt,   gnt0;
    logic [WIDTH-1:0] q,     q0;
    logic [WIDTH-1:0] q_bar, q_bar0;
    logic [1:0]       owner, owner0;
    logic             valid, valid0;
    logic             busy,  busy0;

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .Clk(clk), .reset(reset), .req(req), .data(data),
        .gnt(gnt), .Q(q), .Q_bar(q_bar), .owner(owner), .valid(valid), .busy(busy)
    );

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(0)) dut0 (
        .Clk(clk), .reset(reset), .req(req0), .data(data0),
        .gnt(gnt0), .Q(q0), .Q_bar(q_bar0), .owner(owner0), .valid(valid0), .busy(busy0)
    );

    logic [23:0] act, act0;
    assign act  = {gnt,  q,  q_bar,  owner,  valid,  busy};
    assign act0 = {gnt0, q0, q_bar0, owner0, valid0, busy0};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: m_lock counts the remaining locked cycles after a grant
    int              m_ptr   [2];
    int              m_lock  [2];
    int              m_owner [2];
    logic [WIDTH-1:0] m_q    [2];
    logic            m_valid [2];
    logic [NREQ-1:0] m_gnt   [2];

    initial begin
        for (int n = 0; n < 2; n++) begin
            m_ptr[n] = 0; m_lock[n] = 0; m_owner[n] = 0;
            m_q[n] = '0; m_valid[n] = 1'b0; m_gnt[n] = '0;
        end
    end

    task automatic model_step(input int n, input logic rst, input logic [NREQ-1:0] r,
                              input logic [NREQ*WIDTH-1:0] d, input int hold);
        int w;
        w = -1;
        if (rst) begin
            m_ptr[n] = 0; m_lock[n] = 0; m_owner[n] = 0;
            m_q[n] = '0; m_valid[n] = 1'b0; m_gnt[n] = '0;
        end else if (m_lock[n] > 0) begin
            m_lock[n] = m_lock[n] - 1;
            m_gnt[n]  = '0;
        end else if (r != 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr[n] + k) % NREQ;
                if (w < 0 && r[i]) w = i;
            end
            m_q[n]     = d[w*WIDTH +: WIDTH];
            m_owner[n] = w;
            m_valid[n] = 1'b1;
            m_gnt[n]   = NREQ'(1) << w;
            m_ptr[n]   = (w + 1) % NREQ;
            m_lock[n]  = hold;
        end else begin
            m_gnt[n] = '0;
        end
    endtask

    function automatic logic [23:0] exp_vec(input int n);
        return {m_gnt[n], m_q[n], ~m_q[n], 2'(m_owner[n]), m_valid[n], (m_lock[n] > 0)};
    endfunction

    // One clock: model follows the edge, outputs are then sampled at the falling edge
    task automatic step();
        @(posedge clk);
        model_step(0, reset, req,  data,  HOLD);
        model_step(1, reset, req0, data0, 0);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        data  = 32'h13121110;
        repeat (2) begin
            step();
            checks++;
            if ({gnt, q, q_bar, valid, busy} !== {4'h0, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_state cyc %0d: got %h want %h", cyc,
                         {gnt, q, q_bar, valid, busy}, {4'h0, 8'h00, 8'hFF, 1'b0, 1'b0});
            end
            checks++;
            if (act !== exp_vec(0)) begin
                errors++;
                $display("FAIL reset_model cyc %0d: got %h want %h", cyc, act, exp_vec(0));
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if ({gnt, q} !== {4'b0001, 8'h10}) begin
            errors++;
            $display("FAIL reset_first_grant: got gnt=%b q=%h want gnt=0001 q=10", gnt, q);
        end
    endtask

    task automatic test_single();
        req = '0;
        repeat (HOLD + 1) begin
            step();
            checks++;
            if (act !== exp_vec(0)) begin
                errors++;
                $display("FAIL single_drain cyc %0d: got %h want %h", cyc, act, exp_vec(0));
            end
        end
        data = $urandom;
        data[23:16] = 8'hA5;
        req = 4'b0100;
        step();
        checks++;
        if ({gnt, q, q_bar, owner, valid, busy} !== {4'b0100, 8'hA5, 8'h5A, 2'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_load: got %h want %h", {gnt, q, q_bar, owner, valid, busy},
                     {4'b0100, 8'hA5, 8'h5A, 2'd2, 1'b1, 1'b1});
        end
        req = '0;
        step();
        checks++;
        if (busy !== 1'b1 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_busy2: got busy=%b gnt=%b want busy=1 gnt=0000", busy, gnt);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_end: got busy=%b want 0", busy);
        end
        checks++;
        if (act !== exp_vec(0)) begin
            errors++;
            $display("FAIL single_model: got %h want %h", act, exp_vec(0));
        end
    endtask

    task automatic test_round_robin();
        int         gcyc [$];
        int         gown [$];
        logic [7:0] gq   [$];
        reset = 1'b1; req = '0;
        step();
        reset = 1'b0;
        req   = 4'b1111;
        data  = 32'h13121110;
        for (int c = 1; c <= 13; c++) begin
            step();
            checks++;
            if (act !== exp_vec(0)) begin
                errors++;
                $display("FAIL rr_model cyc %0d: got %h want %h", cyc, act, exp_vec(0));
            end
            if (gnt !== 4'b0000) begin
                gcyc.push_back(c); gown.push_back(int'(owner)); gq.push_back(q);
            end
        end
        req = '0;
        checks++;
        if (gown.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d grants want 5", gown.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (gown[i] != i % 4 || gq[i] !== 8'(16 + i % 4) || gcyc[i] != 1 + 3 * i) begin
                    errors++;
                    $display("FAIL rr_grant%0d: got owner=%0d q=%h cyc=%0d want owner=%0d q=%h cyc=%0d",
                             i, gown[i], gq[i], gcyc[i], i % 4, 8'(16 + i % 4), 1 + 3 * i);
                end
            end
        end
    endtask

    task automatic test_pointer_wrap();
        int gown [$];
        reset = 1'b1; req = '0;
        step();
        reset = 1'b0;
        data  = $urandom;
        req   = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_grant3: got gnt=%b want 1000", gnt);
        end
        req = 4'b0011;
        repeat (8) begin
            step();
            checks++;
            if (act !== exp_vec(0)) begin
                errors++;
                $display("FAIL wrap_model cyc %0d: got %h want %h", cyc, act, exp_vec(0));
            end
            if (gnt !== 4'b0000) gown.push_back(int'(owner));
            req = req & ~m_gnt[0];
        end
        req = '0;
        checks++;
        if (gown.size() != 2 || gown[0] != 0 || gown[1] != 1) begin
            errors++;
            $display("FAIL wrap_order: got %0d grants first=%0d want 2 grants 0 then 1",
                     gown.size(), (gown.size() > 0) ? gown[0] : -1);
        end
    endtask

    task automatic test_lock_ignores();
        reset = 1'b1; req = '0;
        step();
        reset = 1'b0;
        data  = $urandom;
        req   = 4'b0001;
        step();
        req = 4'b0010;
        step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_pulse: got gnt=%b busy=%b want gnt=0000 busy=1", gnt, busy);
        end
        req = '0;
        repeat (2) begin
            step();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL lock_no_grant cyc %0d: got gnt=%b want 0000", cyc, gnt);
            end
        end
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL lock_regrant: got gnt=%b want 0100", gnt);
        end
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (gnt !== ((i == 2) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL lock_held%0d: got gnt=%b want %b", i, gnt,
                         (i == 2) ? 4'b0010 : 4'b0000);
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid_lock();
        reset = 1'b1; req = '0;
        step();
        reset = 1'b0;
        data  = $urandom | 32'h0000_0001;
        req   = 4'b0001;
        step();
        checks++;
        if (busy !== 1'b1 || valid !== 1'b1) begin
            errors++;
            $display("FAIL midlock_pre: got busy=%b valid=%b want 1 1", busy, valid);
        end
        reset = 1'b1;
        req   = '0;
        step();
        checks++;
        if ({busy, q, q_bar, valid, owner, gnt} !== {1'b0, 8'h00, 8'hFF, 1'b0, 2'd0, 4'b0000}) begin
            errors++;
            $display("FAIL midlock_reset: got %h want %h", {busy, q, q_bar, valid, owner, gnt},
                     {1'b0, 8'h00, 8'hFF, 1'b0, 2'd0, 4'b0000});
        end
        reset = 1'b0;
        req   = 4'b1111;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midlock_ptr: got gnt=%b want 0001", gnt);
        end
        req = '0;
    endtask

    task automatic test_hold0();
        reset = 1'b1; req0 = '0;
        step();
        reset = 1'b0;
        data0 = $urandom;
        req0  = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (gnt0 !== ((i % 2 == 0) ? 4'b0001 : 4'b0010) || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL hold0_alt%0d: got gnt=%b busy=%b want gnt=%b busy=0", i, gnt0,
                         busy0, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            end
            checks++;
            if (act0 !== exp_vec(1)) begin
                errors++;
                $display("FAIL hold0_model cyc %0d: got %h want %h", cyc, act0, exp_vec(1));
            end
        end
        req0 = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt[0][i] && $urandom_range(0, 1) == 1) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    data[i*WIDTH +: WIDTH] = 8'($urandom);
                    req[i] = 1'b1;
                end
                if (req0[i] && m_gnt[1][i] && $urandom_range(0, 1) == 1) begin
                    req0[i] = 1'b0;
                end else if (!req0[i] && $urandom_range(0, 2) == 0) begin
                    data0[i*WIDTH +: WIDTH] = 8'($urandom);
                    req0[i] = 1'b1;
                end
            end
            step();
            checks++;
            if (act !== exp_vec(0)) begin
                errors++;
                $display("FAIL random_hold2 cyc %0d: got %h want %h", cyc, act, exp_vec(0));
            end
            checks++;
            if (act0 !== exp_vec(1)) begin
                errors++;
                $display("FAIL random_hold0 cyc %0d: got %h want %h", cyc, act0, exp_vec(1));
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_lock_ignores();
        test_reset_mid_lock();
        test_hold0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
